// File: rtl/m1553_tx_encoder.sv
// rtl/m1553_tx_encoder.sv - MIL-STD-1553 Manchester II word transmitter
module m1553_tx_encoder #(
    parameter int CYCLES_PER_CHIP = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [15:0] tx_word,
    input  logic        tx_type,
    output logic        tx_p,
    output logic        tx_n,
    output logic        tx_en,
    output logic        tx_done
);
    localparam int            CW        = $clog2(CYCLES_PER_CHIP);
    localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLES_PER_CHIP - 1);
    localparam logic [5:0]    SYNC_LAST = 6'd5;
    localparam logic [5:0]    DATA_LAST = 6'd37;
    localparam logic [5:0]    PAR_LAST  = 6'd39;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [5:0]    chip_q, chip_d;
    logic [15:0]   word_q, word_d;
    logic          type_q, type_d;
    logic          par_q, par_d;
    logic          chip_d_val;
    logic          p_d, n_d, en_d, done_d;
    logic          chip_end, word_end, accept;

    // Chip level for word position idx: 0..5 sync, 6..37 data pairs, 38..39 parity pair.
    function automatic logic chip_value(input logic [5:0] idx, input logic [15:0] w,
                                        input logic t, input logic par);
        logic [3:0] bit_sel;
        logic       b;
        bit_sel = 4'((idx - 6'd6) >> 1);
        b       = (idx >= 6'd38) ? par : w[~bit_sel];
        if (idx < 6'd6) begin
            return (idx < 6'd3) ^ t;
        end
        return b ^ idx[0];
    endfunction

    assign chip_end = (cyc_q == CYC_LAST);
    assign word_end = (state_q == PARITY) && (chip_q == PAR_LAST) && chip_end;
    assign tx_ready = (state_q == IDLE) || word_end;
    assign accept   = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SYNC;
            SYNC:    if (chip_end && chip_q == SYNC_LAST) state_d = DATA;
            DATA:    if (chip_end && chip_q == DATA_LAST) state_d = PARITY;
            PARITY:  if (word_end) state_d = accept ? SYNC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from next-state values so the registered bus drive lines up with state.
    always_comb begin : next_outputs
        word_d = accept ? tx_word : word_q;
        type_d = accept ? tx_type : type_q;
        par_d  = accept ? ~^tx_word : par_q;
        if (state_d == IDLE || accept) begin
            cyc_d  = '0;
            chip_d = '0;
        end else if (chip_end) begin
            cyc_d  = '0;
            chip_d = chip_q + 6'd1;
        end else begin
            cyc_d  = cyc_q + 1'b1;
            chip_d = chip_q;
        end
        en_d       = (state_d != IDLE);
        chip_d_val = chip_value(chip_d, word_d, type_d, par_d);
        p_d        = en_d & chip_d_val;
        n_d        = en_d & ~chip_d_val;
        done_d     = (state_d == PARITY) && (chip_d == PAR_LAST) && (cyc_d == CYC_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin : datapath_reg
        if (!rst_n) begin
            cyc_q   <= '0;
            chip_q  <= '0;
            word_q  <= '0;
            type_q  <= 1'b0;
            par_q   <= 1'b0;
            tx_p    <= 1'b0;
            tx_n    <= 1'b0;
            tx_en   <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            chip_q  <= chip_d;
            word_q  <= word_d;
            type_q  <= type_d;
            par_q   <= par_d;
            tx_p    <= p_d;
            tx_n    <= n_d;
            tx_en   <= en_d;
            tx_done <= done_d;
        end
    end
endmodule

// File: tb/tb_m1553_tx_encoder.sv
// tb/tb_m1553_tx_encoder.sv - scoreboard bench for m1553_tx_encoder at two chip rates
module tb_m1553_tx_encoder;
    localparam int CPC0 = 50;
    localparam int CPC1 = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  valid;
    logic [15:0] word0, word1;
    logic        type0, type1;
    logic [1:0]  ready, p, n, en, done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit q0[$];
    bit q1[$];
    int dt0[$];
    int dt1[$];
    int k[2];
    int nchip[2];
    bit cur[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    m1553_tx_encoder u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid[0]), .tx_ready(ready[0]),
        .tx_word(word0), .tx_type(type0), .tx_p(p[0]), .tx_n(n[0]),
        .tx_en(en[0]), .tx_done(done[0])
    );

    m1553_tx_encoder #(.CYCLES_PER_CHIP(CPC1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid[1]), .tx_ready(ready[1]),
        .tx_word(word1), .tx_type(type1), .tx_p(p[1]), .tx_n(n[1]),
        .tx_en(en[1]), .tx_done(done[1])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_word(input int i, input logic [15:0] w, input logic t);
        bit c[$];
        for (int s = 0; s < 6; s++) c.push_back((s < 3) ? ~t : t);
        for (int b = 15; b >= 0; b--) begin
            c.push_back(w[b]);
            c.push_back(~w[b]);
        end
        c.push_back(~^w);
        c.push_back(^w);
        foreach (c[j]) begin
            if (i == 0) q0.push_back(c[j]);
            else        q1.push_back(c[j]);
        end
    endtask

    task automatic send(input int i, input logic [15:0] w, input logic t, input bit hold,
                        output int acc);
        int guard;
        push_word(i, w, t);
        @(negedge clk);
        if (i == 0) begin valid[0] = 1'b1; word0 = w; type0 = t; end
        else        begin valid[1] = 1'b1; word1 = w; type1 = t; end
        guard = 0;
        while (!ready[i] && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", ready[i], 1);
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        check("start_en", en[i], 1);
        if (!hold) begin
            valid[i] = 1'b0;
            if (i == 0) begin word0 = 16'($urandom); type0 = ~type0; end
            else        begin word1 = 16'($urandom); type1 = ~type1; end
        end
    endtask

    task automatic wait_done(input int i, output int t);
        int guard;
        guard = 0;
        while (!done[i] && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", done[i], 1);
        t = cyc;
    endtask

    task automatic run_single(input int i, input logic [15:0] w, input logic t);
        int acc, td;
        send(i, w, t, 1'b0, acc);
        wait_done(i, td);
        check("word_len", td - acc, 40 * ((i == 0) ? CPC0 : CPC1) - 1);
        @(negedge clk);
        check("en_fall", en[i], 0);
    endtask

    initial begin
        k     = '{0, 0};
        nchip = '{0, 0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int   cpc;
                logic exp_done;
                cpc = (i == 0) ? CPC0 : CPC1;
                if (!rst_n) begin
                    k[i]     = 0;
                    nchip[i] = 0;
                end else if (k[i] == 0 && nchip[i] == 0 && !en[i]) begin
                    check("idle", {p[i], n[i], done[i], ready[i]}, 4'b0001);
                end else begin
                    if (k[i] == 0) begin
                        check("q_avail", ((i == 0) ? q0.size() : q1.size()) > 0, 1);
                        if (i == 0 && q0.size() > 0)      cur[i] = q0.pop_front();
                        else if (i == 1 && q1.size() > 0) cur[i] = q1.pop_front();
                    end
                    exp_done = (nchip[i] == 39) && (k[i] == cpc - 1);
                    check("chip", {en[i], p[i], n[i], done[i], ready[i]},
                          {1'b1, cur[i], ~cur[i], exp_done, exp_done});
                    if (done[i]) begin
                        if (i == 0) dt0.push_back(cyc);
                        else        dt1.push_back(cyc);
                    end
                    k[i]++;
                    if (k[i] == cpc) begin
                        k[i]     = 0;
                        nchip[i] = (nchip[i] == 39) ? 0 : nchip[i] + 1;
                    end
                end
            end
        end
    end

    initial begin
        int acc1, acc2, td;
        rst_n = 1'b0;
        valid = 2'b00;
        word0 = '0; word1 = '0;
        type0 = 1'b0; type1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out0", {p[0], n[0], en[0], done[0]}, 0);
        check("rst_out1", {p[1], n[1], en[1], done[1]}, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_rst0", ready[0], 1);
        check("rdy_after_rst1", ready[1], 1);

        run_single(0, 16'h0000, 1'b0);
        run_single(0, 16'hFFFF, 1'b1);
        run_single(0, 16'h0001, 1'b1);

        send(0, 16'hA5C3, 1'b0, 1'b1, acc1);
        send(0, 16'h1234, 1'b1, 1'b0, acc2);
        check("b2b_accept_gap", acc2 - acc1, 40 * CPC0);
        wait_done(0, td);
        @(negedge clk);
        check("b2b_en_fall", en[0], 0);
        check("b2b_done_cnt", dt0.size(), 5);
        if (dt0.size() >= 2) check("b2b_done_gap", dt0[dt0.size()-1] - dt0[dt0.size()-2], 40 * CPC0);

        run_single(1, 16'h0000, 1'b0);
        run_single(1, 16'h8001, 1'b1);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("done_cnt1", dt1.size(), 2);

        send(0, 16'hBEEF, 1'b1, 1'b0, acc1);
        repeat ((6 + 10) * CPC0 + 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_out", {p[0], n[0], en[0], done[0]}, 0);
        check("abort_rdy", ready[0], 1);
        q0.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_rdy", ready[0], 1);
        check("post_abort_en", en[0], 0);
        repeat (100) @(negedge clk);
        check("post_abort_idle", {en[0], done[0]}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/m1553_tx_encoder.md
M1553_TX_ENCODER -- requirements
Module: m1553_tx_encoder

Interface
REQ-001 SHALL have parameter CYCLES_PER_CHIP, default 50, meaning clock cycles per Manchester chip (half bit); legal values >= 2.
REQ-002 SHALL have port clk, input, 1, master clock (100 MHz nominal).
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tx_valid, input, 1, word offered for transmission.
REQ-005 SHALL have port tx_ready, output, 1, encoder accepts the word this cycle.
REQ-006 SHALL have port tx_word, input, 16, data bits; bit 15 is transmitted first.
REQ-007 SHALL have port tx_type, input, 1, word type: 0 = CMD_WORD (command/status), 1 = DATA_WORD.
REQ-008 SHALL have port tx_p, output, 1, positive bus drive.
REQ-009 SHALL have port tx_n, output, 1, negative bus drive.
REQ-010 SHALL have port tx_en, output, 1, transceiver driver enable.
REQ-011 SHALL have port tx_done, output, 1, one-cycle pulse at the end of each word.

Function
REQ-012 SHALL accept a word on a cycle with tx_valid && tx_ready, and capture tx_word, tx_type and odd parity (~^tx_word).
REQ-013 SHALL assert tx_ready combinationally in IDLE, and in the final clock cycle of the last parity chip; it is low at all other times.
REQ-014 SHALL implement the states IDLE, SYNC, DATA and PARITY.
REQ-015 SHALL go IDLE->SYNC on accept; SYNC->DATA after 6 chips; DATA->PARITY after 32 chips; PARITY->IDLE after 2 chips, or PARITY->SYNC if a word is accepted in the final cycle.
REQ-016 SHALL hold each chip for exactly CYCLES_PER_CHIP cycles, so one word = 40 chips = 40*CYCLES_PER_CHIP cycles (2000 at default).
REQ-017 SHALL drive the SYNC chips for CMD_WORD as 1,1,1,0,0,0.
REQ-018 SHALL drive the SYNC chips for DATA_WORD as 0,0,0,1,1,1.
REQ-019 SHALL encode each data bit and the parity bit as the chip pair 1 -> 10 and 0 -> 01, first chip first.
REQ-020 SHALL register all outputs; the first sync chip appears on the cycle after the accept cycle.
REQ-021 SHALL drive tx_p = chip and tx_n = ~chip while tx_en = 1.
REQ-022 SHALL drive tx_p = tx_n = 0 while tx_en = 0.
REQ-023 SHALL hold tx_en high from the first sync chip through the last parity chip.
REQ-024 SHALL keep tx_en high with no gap cycle on a back-to-back accept; otherwise tx_en falls on the cycle after the last parity chip.
REQ-025 SHALL pulse tx_done for one cycle coincident with the final cycle of the last parity chip, independent of back-to-back continuation.
REQ-026 SHALL ignore tx_word and tx_type changes after accept until the next accept.
REQ-027 SHALL size the chip-cycle counter as $clog2(CYCLES_PER_CHIP) bits and the chip index as 6 bits (0..39); neither counter wraps inside a word.

Reset
REQ-028 SHALL, while rst_n = 0, asynchronously force state = IDLE, tx_p = 0, tx_n = 0, tx_en = 0, tx_done = 0 and clear both counters.
REQ-029 SHALL abort a word in progress when reset is asserted mid-word; no partial word resumes.
REQ-030 SHALL present tx_ready = 1 on the first cycle after rst_n deasserts.

Verification
REQ-031 SHALL cover: CMD_WORD 16'h0000 -> chips 111000, then 01 x16, then parity 10; each chip 50 cycles; tx_done at cycle 2000 after the first sync chip.
REQ-032 SHALL cover: DATA_WORD 16'hFFFF -> chips 000111, then 10 x16, then parity 10; tx_n = ~tx_p throughout.
REQ-033 SHALL cover: DATA_WORD 16'h0001 -> parity chips 01; the last data bit (bit 0) is sent as 10.
REQ-034 SHALL cover: tx_valid held high with two words -> the second sync starts on the cycle after the first parity ends; tx_en never drops; two tx_done pulses 2000 cycles apart.
REQ-035 SHALL cover: rst_n pulsed low during DATA chip 10 -> outputs are 0 immediately, the state returns to IDLE, and tx_ready = 1 after release.
REQ-036 SHALL cover: CYCLES_PER_CHIP = 4 override -> the word lasts 160 cycles with an identical chip pattern.
